edit_mod_counter: RTL and testbench
===================================

Name: edit_mod_counter

Overview:
- Parametrised successor to the fixed hour counter: a modulo-N time-unit counter (hours, minutes, seconds, days) with carry chaining, per-digit BCD editing, a half-range toggle and auto-repeat on held keys.
- Sits in the clock datapath. It is chained from the lower unit's carry_out into the next unit's tick_in.
- Its edit controls are driven by the edit/screen controller.

Parameters:
- MODULUS, 24: count range 0..MODULUS-1. Legal range 2..100.
- WIDTH, 5: width of value. Must satisfy 2^WIDTH >= MODULUS.
- REPEAT_DELAY, 50: cycles a key must be held before the first auto-repeat step. 0 disables auto-repeat.
- REPEAT_RATE, 10: cycles between subsequent auto-repeat steps. Must be >= 1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- tick_in, input, 1: single-cycle increment request from the lower unit or the prescaler.
- load_en, input, 1: loads load_value.
- load_value, input, WIDTH: preset value.
- edit_en, input, 1: edit mode. Counting is frozen while high.
- edit_sel, input, 2: edit target. 0 = units digit, 1 = tens digit, 2 = half toggle, 3 = none.
- key_plus_n, input, 1: active-low, debounced.
- key_minus_n, input, 1: active-low, debounced.
- value, output, WIDTH: current count, registered.
- value_tens, output, 4: BCD tens of value, registered.
- value_units, output, 4: BCD units of value, registered.
- carry_out, output, 1: one-cycle wrap pulse, registered.

Behaviour:
- Reset: value=0, value_tens=0, value_units=0, carry_out=0. Key history registers=1 (released). Hold counter=0.
- Priority per cycle: reset > load_en > tick (only when edit_en=0) > key step (only when edit_en=1).
- Load: value <= min(load_value, MODULUS-1). No carry.
- Tick:
  - If value==MODULUS-1: value <= 0 and carry_out=1 in the following cycle.
  - Otherwise value <= value+1.
  - tick_in is ignored (dropped, not queued) while edit_en=1.
- carry_out is high for exactly one cycle per wrap and low otherwise. Loads and edits never assert it.
- BCD outputs are computed from the next-state value, so they are always consistent with value in the same cycle.
- Key press detection:
  - A step fires on the edge where key_n=0 and its history bit=1.
  - The updated value is visible immediately after that edge (1-cycle latency from the sampled low level).
  - Both keys low simultaneously: no step, and the hold counter is cleared.
  - A press while edit_en=0 or edit_sel=3 is ignored, but history still updates.
- Auto-repeat (REPEAT_DELAY>0):
  - While a single key stays low and edit_en=1, the hold counter increments every cycle from the initial step.
  - A repeat step fires when the counter reaches REPEAT_DELAY, then every REPEAT_RATE cycles after that.
  - Release, the other key pressing, edit_en falling, or a change of edit_sel clears the counter.
- Units edit, with u=value%10 and t=value/10:
  - plus: if u==9 or value==MODULUS-1, then value <= t*10. Otherwise value+1.
  - minus: if u==0, then value <= t*10 + min(9, MODULUS-1-t*10). Otherwise value-1.
- Tens edit:
  - plus: if value+10 >= MODULUS, then value <= u. Otherwise value+10.
  - minus: if t>0, then value-10. Otherwise value <= T*10+u, where T is the largest T with T*10+u < MODULUS.
- Half toggle (both keys act the same):
  - Only when MODULUS is even; otherwise no-op.
  - If value < MODULUS/2, then value+MODULUS/2. Otherwise value-MODULUS/2.
- Edits never change other units and never produce carry.
- Reset asserted mid-hold: all state returns to reset values. A key still held after reset deasserts does not step until it is released and pressed again.
- Loading or editing a value outside range is impossible; all results stay in 0..MODULUS-1.

Test Plan:
1. MODULUS=24, value=23, tick_in pulse -> value=0, value_tens=0, value_units=0, and carry_out=1 for exactly the next cycle only.
2. MODULUS=24, edit_en=1, edit_sel=0, value=23, key_plus_n falls -> value=20. Then key_minus_n press -> value=23. From value=19, minus twice -> 18, 17.
3. MODULUS=24, edit_sel=1, value=09, minus -> 19. Minus again -> 09. Plus from 19 -> 09. MODULUS=60, value=57, plus -> 07.
4. MODULUS=24, edit_sel=2, value=5 -> 17 -> 5. MODULUS=59, toggle -> value unchanged.
5. REPEAT_DELAY=50, REPEAT_RATE=10, key_plus_n held low 80 cycles, edit_sel=0, start 0 -> steps at press cycle, +50 and +60 (+70 lands at cycle 80: check boundary). Both keys low -> no change.
6. Priority: load_en=1 with load_value=31 and tick_in=1 in the same cycle (MODULUS=24) -> value=23, no carry. tick_in with edit_en=1 -> value unchanged. Reset while key held -> value=0, no step until release and re-press.

Source files
------------

// File: rtl/edit_mod_counter.sv
`default_nettype none
// ============================================================================
// Module  : edit_mod_counter
// Brief   : Modulo-N time-unit counter with carry chaining, BCD digit editing,
//           half-range toggle and key auto-repeat.
// Revision: 1.0
// ============================================================================
module edit_mod_counter #(
    parameter int MODULUS      = 24,
    parameter int WIDTH        = 5,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic             edit_en,
    input  logic [1:0]       edit_sel,
    input  logic             key_plus_n,
    input  logic             key_minus_n,
    output logic [WIDTH-1:0] value,
    output logic [3:0]       value_tens,
    output logic [3:0]       value_units,
    output logic             carry_out
);

    localparam int c_cnt_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_delay  = c_cnt_w'(REPEAT_DELAY);
    localparam logic [c_cnt_w-1:0] c_rate   = c_cnt_w'(REPEAT_RATE);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
    localparam logic               c_rep_en = (REPEAT_DELAY > 0);
    localparam logic               c_even   = ((MODULUS % 2) == 0);
    localparam logic [7:0]         c_mod    = 8'(MODULUS);
    localparam logic [7:0]         c_top    = 8'(MODULUS - 1);
    localparam logic [7:0]         c_half   = 8'(MODULUS / 2);
    localparam logic [WIDTH-1:0]   c_top_w  = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0]   r_value;
    logic [3:0]         r_tens;
    logic [3:0]         r_units;
    logic               r_carry;
    logic               r_plus_hist;
    logic               r_minus_hist;
    logic               r_plus_lock;
    logic               r_minus_lock;
    logic [c_cnt_w-1:0] r_hold_cnt;
    logic               r_repeating;
    logic [1:0]         r_sel_prev;

    logic [7:0] w_cur;
    logic [7:0] w_t;
    logic [7:0] w_u;
    logic [7:0] w_t10;
    logic [7:0] w_grp_room;
    logic [7:0] w_edit;
    logic [7:0] w_next;
    logic       w_wrap;
    logic       w_plus_low;
    logic       w_minus_low;
    logic       w_edit_ok;
    logic       w_press;
    logic       w_hold_ok;
    logic       w_rep_fire;
    logic       w_step;

    assign w_cur       = 8'(r_value);
    assign w_t         = w_cur / 8'd10;
    assign w_u         = w_cur % 8'd10;
    assign w_t10       = w_t * 8'd10;
    assign w_grp_room  = c_top - w_t10;

    assign w_plus_low  = !key_plus_n && key_minus_n;
    assign w_minus_low = !key_minus_n && key_plus_n;
    assign w_edit_ok   = edit_en && (edit_sel != 2'd3);

    // Lock bits keep a key held through reset from stepping until re-pressed.
    assign w_press    = w_edit_ok &&
                        ((w_plus_low && r_plus_hist && !r_plus_lock) ||
                         (w_minus_low && r_minus_hist && !r_minus_lock));
    assign w_hold_ok  = c_rep_en && w_edit_ok && (w_plus_low || w_minus_low) &&
                        (edit_sel == r_sel_prev) && (r_hold_cnt != '0);
    assign w_rep_fire = w_hold_ok && (r_repeating ? (r_hold_cnt == c_rate)
                                                  : (r_hold_cnt == c_delay));
    assign w_step     = w_press || w_rep_fire;

    always_comb begin
        w_edit = w_cur;
        case (edit_sel)
            2'd0: begin
                if (w_plus_low) begin
                    w_edit = ((w_u == 8'd9) || (w_cur == c_top)) ? w_t10 : w_cur + 8'd1;
                end else begin
                    w_edit = (w_u == 8'd0) ? w_t10 + ((w_grp_room > 8'd9) ? 8'd9 : w_grp_room)
                                           : w_cur - 8'd1;
                end
            end
            2'd1: begin
                if (w_plus_low) begin
                    w_edit = ((w_cur + 8'd10) >= c_mod) ? w_u : w_cur + 8'd10;
                end else begin
                    w_edit = (w_t != 8'd0) ? w_cur - 8'd10
                                           : (((c_top - w_u) / 8'd10) * 8'd10) + w_u;
                end
            end
            2'd2: begin
                if (c_even) begin
                    w_edit = (w_cur < c_half) ? w_cur + c_half : w_cur - c_half;
                end
            end
            default: w_edit = w_cur;
        endcase
    end

    always_comb begin
        w_next = w_cur;
        w_wrap = 1'b0;
        if (load_en) begin
            w_next = (load_value > c_top_w) ? c_top : 8'(load_value);
        end else if (tick_in && !edit_en) begin
            if (w_cur == c_top) begin
                w_next = 8'd0;
                w_wrap = 1'b1;
            end else begin
                w_next = w_cur + 8'd1;
            end
        end else if (w_step) begin
            w_next = w_edit;
        end
    end

    always_ff @(posedge clk) begin
        r_sel_prev <= edit_sel;
        if (reset) begin
            r_value      <= '0;
            r_tens       <= '0;
            r_units      <= '0;
            r_carry      <= 1'b0;
            r_plus_hist  <= 1'b1;
            r_minus_hist <= 1'b1;
            r_plus_lock  <= ~key_plus_n;
            r_minus_lock <= ~key_minus_n;
            r_hold_cnt   <= '0;
            r_repeating  <= 1'b0;
        end else begin
            r_value      <= WIDTH'(w_next);
            r_tens       <= 4'(w_next / 8'd10);
            r_units      <= 4'(w_next % 8'd10);
            r_carry      <= w_wrap;
            r_plus_hist  <= key_plus_n;
            r_minus_hist <= key_minus_n;
            r_plus_lock  <= r_plus_lock & ~key_plus_n;
            r_minus_lock <= r_minus_lock & ~key_minus_n;
            if (w_press) begin
                r_hold_cnt  <= c_rep_en ? c_one : '0;
                r_repeating <= 1'b0;
            end else if (w_hold_ok) begin
                if (w_rep_fire) begin
                    r_hold_cnt  <= c_one;
                    r_repeating <= 1'b1;
                end else begin
                    r_hold_cnt  <= r_hold_cnt + c_one;
                end
            end else begin
                r_hold_cnt  <= '0;
                r_repeating <= 1'b0;
            end
        end
    end

    assign value       = r_value;
    assign value_tens  = r_tens;
    assign value_units = r_units;
    assign carry_out   = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_edit_mod_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_edit_mod_counter
// Brief   : Three counter instances (mod 24, 60, 59) on shared stimulus, checked
//           against a digit-group reference model. Revision: 1.0
// ============================================================================
module tb_edit_mod_counter;

    localparam int DLY = 50;
    localparam int RT  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, tick_in, load_en, edit_en, key_plus_n, key_minus_n;
    logic [1:0] edit_sel;
    logic [6:0] load_value;
    logic [4:0] v0;
    logic [5:0] v1, v2;
    logic [3:0] t0, u0, t1, u1, t2, u2;
    logic       c0, c1, c2;

    edit_mod_counter #(.MODULUS(24), .WIDTH(5), .REPEAT_DELAY(DLY), .REPEAT_RATE(RT)) u_m24 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .load_en(load_en),
        .load_value(load_value[4:0]), .edit_en(edit_en), .edit_sel(edit_sel),
        .key_plus_n(key_plus_n), .key_minus_n(key_minus_n),
        .value(v0), .value_tens(t0), .value_units(u0), .carry_out(c0));
    edit_mod_counter #(.MODULUS(60), .WIDTH(6), .REPEAT_DELAY(DLY), .REPEAT_RATE(RT)) u_m60 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .load_en(load_en),
        .load_value(load_value[5:0]), .edit_en(edit_en), .edit_sel(edit_sel),
        .key_plus_n(key_plus_n), .key_minus_n(key_minus_n),
        .value(v1), .value_tens(t1), .value_units(u1), .carry_out(c1));
    edit_mod_counter #(.MODULUS(59), .WIDTH(6), .REPEAT_DELAY(DLY), .REPEAT_RATE(RT)) u_m59 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .load_en(load_en),
        .load_value(load_value[5:0]), .edit_en(edit_en), .edit_sel(edit_sel),
        .key_plus_n(key_plus_n), .key_minus_n(key_minus_n),
        .value(v2), .value_tens(t2), .value_units(u2), .carry_out(c2));

    int n_assert = 0;
    int n_fail   = 0;

    int mods[3]  = '{24, 60, 59};
    int masks[3] = '{31, 63, 63};
    int mv[3];
    bit mc[3];
    bit hist_p, hist_m, lock_p, lock_m, holding;
    bit [1:0] sel_prev;
    int press_t, cyc;

    // Edits step cyclically through the legal values sharing a tens digit
    // (units edit) or sharing a units digit (tens edit).
    function automatic int edit_f(int v, int m, int sel, bit plus);
        int stp, base, n, idx;
        if (sel == 2) return (m % 2 == 0) ? (v + m / 2) % m : v;
        if (sel == 3) return v;
        stp  = (sel == 0) ? 1 : 10;
        base = (sel == 0) ? (v / 10) * 10 : v % 10;
        n = 0;
        for (int k = 0; k < 10; k++)
            if (base + k * stp < m) n++;
        idx = (v - base) / stp;
        return base + ((idx + (plus ? 1 : n - 1)) % n) * stp;
    endfunction

    task automatic model_update();
        bit plow, mlow, press, rep;
        int age;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin mv[i] = 0; mc[i] = 0; end
            hist_p = 1; hist_m = 1;
            lock_p = !key_plus_n; lock_m = !key_minus_n;
            holding = 0;
        end else begin
            plow  = !key_plus_n && key_minus_n;
            mlow  = !key_minus_n && key_plus_n;
            press = edit_en && edit_sel != 2'd3 &&
                    ((plow && hist_p && !lock_p) || (mlow && hist_m && !lock_m));
            rep = 0;
            if (press) begin
                holding = (DLY > 0);
                press_t = cyc;
            end else if (holding && edit_en && edit_sel != 2'd3 && (plow || mlow) &&
                         edit_sel == sel_prev) begin
                age = cyc - press_t;
                rep = (age >= DLY) && ((age - DLY) % RT == 0);
            end else begin
                holding = 0;
            end
            for (int i = 0; i < 3; i++) begin
                mc[i] = 0;
                if (load_en) begin
                    mv[i] = ((int'(load_value) & masks[i]) > mods[i] - 1) ?
                            mods[i] - 1 : (int'(load_value) & masks[i]);
                end else if (tick_in && !edit_en) begin
                    mc[i] = (mv[i] == mods[i] - 1);
                    mv[i] = (mv[i] + 1) % mods[i];
                end else if (press || rep) begin
                    mv[i] = edit_f(mv[i], mods[i], int'(edit_sel), plow);
                end
            end
            hist_p = key_plus_n;  hist_m = key_minus_n;
            lock_p = lock_p && !key_plus_n;
            lock_m = lock_m && !key_minus_n;
        end
        sel_prev = edit_sel;
        cyc++;
    endtask

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("m24_value", 8'(v0), 8'(mv[0]));
        check("m24_tens",  8'(t0), 8'(mv[0] / 10));
        check("m24_units", 8'(u0), 8'(mv[0] % 10));
        check("m24_carry", 8'(c0), 8'(mc[0]));
        check("m60_value", 8'(v1), 8'(mv[1]));
        check("m60_tens",  8'(t1), 8'(mv[1] / 10));
        check("m60_units", 8'(u1), 8'(mv[1] % 10));
        check("m60_carry", 8'(c1), 8'(mc[1]));
        check("m59_value", 8'(v2), 8'(mv[2]));
        check("m59_tens",  8'(t2), 8'(mv[2] / 10));
        check("m59_units", 8'(u2), 8'(mv[2] % 10));
        check("m59_carry", 8'(c2), 8'(mc[2]));
    endtask

    task automatic cycle(int n = 1);
        for (int k = 0; k < n; k++) begin
            model_update();
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    task automatic load(int v);
        load_en = 1; load_value = 7'(v);
        cycle();
        load_en = 0;
    endtask

    task automatic tap_plus();
        key_plus_n = 0; cycle(); key_plus_n = 1; cycle();
    endtask

    task automatic tap_minus();
        key_minus_n = 0; cycle(); key_minus_n = 1; cycle();
    endtask

    initial begin
        reset = 1; tick_in = 0; load_en = 0; load_value = 0; edit_en = 0;
        edit_sel = 2'd3; key_plus_n = 1; key_minus_n = 1;
        cyc = 0; press_t = 0; sel_prev = 2'd3;
        cycle(2);
        reset = 0;
        check("reset_value", 8'(v0), 8'd0);

        // Wrap with one-cycle carry
        load(23);
        tick_in = 1; cycle(); tick_in = 0;
        check("wrap_value", 8'(v0), 8'd0);
        check("wrap_carry", 8'(c0), 8'd1);
        cycle();
        check("carry_one_cycle", 8'(c0), 8'd0);

        // Units edit
        edit_en = 1; edit_sel = 2'd0; load(23);
        key_plus_n = 0; cycle();
        check("units_plus_top", 8'(v0), 8'd20);
        key_plus_n = 1; cycle();
        tap_minus();
        check("units_minus_zero", 8'(v0), 8'd23);
        load(19); tap_minus(); tap_minus();
        check("units_minus_twice", 8'(v0), 8'd17);

        // Tens edit
        edit_sel = 2'd1; load(9);
        tap_minus();
        check("tens_minus_wrap", 8'(v0), 8'd19);
        tap_minus();
        check("tens_minus", 8'(v0), 8'd9);
        load(19); tap_plus();
        check("tens_plus_wrap", 8'(v0), 8'd9);
        load(57); tap_plus();
        check("m60_tens_plus", 8'(v1), 8'd7);

        // Half toggle
        edit_sel = 2'd2; load(5);
        tap_plus();
        check("toggle_up", 8'(v0), 8'd17);
        check("toggle_odd_mod", 8'(v2), 8'd5);
        tap_minus();
        check("toggle_down", 8'(v0), 8'd5);

        // Auto-repeat and both-keys
        edit_sel = 2'd0; load(0); cycle();
        key_plus_n = 0; cycle(80); key_plus_n = 1; cycle();
        check("repeat_count", 8'(v0), 8'd4);
        key_plus_n = 0; cycle(); key_minus_n = 0; cycle(60);
        key_plus_n = 1; key_minus_n = 1; cycle();
        check("both_keys", 8'(v0), 8'd5);

        // Priority
        edit_en = 0; load_en = 1; load_value = 7'd31; tick_in = 1; cycle();
        load_en = 0;
        check("load_beats_tick", 8'(v0), 8'd23);
        check("load_no_carry", 8'(c0), 8'd0);
        edit_en = 1; cycle(); tick_in = 0;
        check("tick_dropped_edit", 8'(v0), 8'd23);

        // Reset mid-hold
        load(5); key_plus_n = 0; cycle(4);
        reset = 1; cycle(); reset = 0; cycle(5);
        check("held_through_reset", 8'(v0), 8'd0);
        key_plus_n = 1; cycle(); key_plus_n = 0; cycle();
        check("repress_after_reset", 8'(v0), 8'd1);
        key_plus_n = 1; cycle();

        // Randomized phase: short holds, then long holds to exercise repeat
        for (int n = 0; n < 1600; n++) begin
            reset      = ($urandom_range(0, 199) == 0);
            load_en    = ($urandom_range(0, 19) == 0);
            load_value = 7'($urandom_range(0, 127));
            tick_in    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 29) == 0) edit_en = ~edit_en;
            if ($urandom_range(0, 39) == 0) edit_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, (n < 800) ? 7 : 69) == 0) key_plus_n = ~key_plus_n;
            if ($urandom_range(0, (n < 800) ? 7 : 69) == 0) key_minus_n = ~key_minus_n;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
